// File: rtl/sata_rx_dword_align_if.sv
// sata_rx_dword_align_if: raw GTX receive side and aligned link-layer side
// of the receive dword aligner.
//
// Valid semantics: there is no ready/backpressure on either side. The
// raw side presents one word every clk_75m cycle. On the aligned side,
// phy2cs_data and phy2cs_k carry meaning only in a cycle where
// phy2cs_valid is 1. The consumer must take the word in that same cycle.
interface sata_rx_dword_align_if;
  logic [31:0] rxdata_fis;
  logic [3:0]  rxcharisk;
  logic [31:0] phy2cs_data;
  logic        phy2cs_k;
  logic        phy2cs_valid;

  modport master (
    output rxdata_fis, rxcharisk,
    input  phy2cs_data, phy2cs_k, phy2cs_valid
  );

  modport slave (
    input  rxdata_fis, rxcharisk,
    output phy2cs_data, phy2cs_k, phy2cs_valid
  );
endinterface

// File: rtl/sata_rx_dword_align.sv
// sata_rx_dword_align: finds the K28.5 comma lane in the raw GTX receive
// stream and rotates each dword so the primitive byte sits in lane 0.
// An UNSYNC/ACQ/SYNC state machine tracks lock. Aligned dwords leave two
// cycles after entry with a fixed latency for every lane.
// Optional build macro SATA_RX_ALIGN_DROP_EN: when it is defined, aligned
// ALIGN primitives are output with phy2cs_valid=0. align_det pulses for
// them in both builds.
module sata_rx_dword_align #(
  parameter int C_LOCK_CNT = 3,
  parameter int C_LOSS_CNT = 4
) (
  input  logic                         clk_75m,
  input  logic                         host_rst,
  input  logic                         link_up,
  sata_rx_dword_align_if.slave         bus,
  output logic                         rx_locked,
  output logic [1:0]                   align_shift,
  output logic                         align_det,
  output logic                         rx_err,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    ACQ    = 2'd1,
    SYNC   = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_PRIM = 32'h7B4A_4ABC;
  localparam logic [3:0]  LOCK_CNT   = 4'(C_LOCK_CNT);
  localparam logic [3:0]  LOSS_CNT   = 4'(C_LOSS_CNT);
`ifdef SATA_RX_ALIGN_DROP_EN
  localparam logic DROP_ALIGN = 1'b1;
`else
  localparam logic DROP_ALIGN = 1'b0;
`endif

  state_t      state, state_nx;
  logic [1:0]  p, p_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  errcnt, errcnt_nx;
  logic        err_nx;

  logic        comma;
  logic [1:0]  comma_lane;
  logic        good_word;

  logic [31:0] d1_data;
  logic [3:0]  d1_k;
  logic        d1_tag;     // d1 word entered while locked (and link up)
  logic [31:0] aligned_data;
  logic        aligned_k;
  logic        is_align;
  logic        qual;

  // Comma test: exactly one K flag set, and that byte carries 0xBC.
  always_comb begin
    comma      = 1'b0;
    comma_lane = 2'd0;
    case (bus.rxcharisk)
      4'b0001: begin comma = (bus.rxdata_fis[7:0]   == 8'hBC); comma_lane = 2'd0; end
      4'b0010: begin comma = (bus.rxdata_fis[15:8]  == 8'hBC); comma_lane = 2'd1; end
      4'b0100: begin comma = (bus.rxdata_fis[23:16] == 8'hBC); comma_lane = 2'd2; end
      4'b1000: begin comma = (bus.rxdata_fis[31:24] == 8'hBC); comma_lane = 2'd3; end
      default: begin comma = 1'b0; comma_lane = 2'd0; end
    endcase
  end

  assign good_word = (bus.rxcharisk == 4'b0000) || (bus.rxcharisk == (4'b0001 << p));

  // Next-state logic. A low link_up overrides every other transition.
  always_comb begin
    state_nx  = state;
    p_nx      = p;
    cnt_nx    = cnt;
    errcnt_nx = errcnt;
    err_nx    = 1'b0;
    if (!link_up) begin
      state_nx  = UNSYNC;
      cnt_nx    = 4'd0;
      errcnt_nx = 4'd0;
    end else begin
      case (state)
        UNSYNC: begin
          if (comma) begin
            p_nx     = comma_lane;
            cnt_nx   = 4'd1;
            state_nx = (LOCK_CNT == 4'd1) ? SYNC : ACQ;
          end
        end
        ACQ: begin
          if (comma && (comma_lane == p)) begin
            cnt_nx = cnt + 4'd1;
            if ((cnt + 4'd1) == LOCK_CNT) state_nx = SYNC;
          end else if (comma) begin
            p_nx   = comma_lane;
            cnt_nx = 4'd1;
            if (LOCK_CNT == 4'd1) state_nx = SYNC;
          end else if (bus.rxcharisk != 4'b0000) begin
            state_nx = UNSYNC;
            cnt_nx   = 4'd0;
          end
        end
        SYNC: begin
          if (good_word) begin
            errcnt_nx = 4'd0;
          end else begin
            err_nx    = 1'b1;
            errcnt_nx = errcnt + 4'd1;
            if ((errcnt + 4'd1) == LOSS_CNT) begin
              state_nx  = UNSYNC;
              errcnt_nx = 4'd0;
              cnt_nx    = 4'd0;
            end
          end
        end
        default: begin
          state_nx  = UNSYNC;
          cnt_nx    = 4'd0;
          errcnt_nx = 4'd0;
        end
      endcase
    end
  end

  // State, comma lane and counters.
  always_ff @(posedge clk_75m or posedge host_rst) begin
    if (host_rst) begin
      state  <= UNSYNC;
      p      <= 2'd0;
      cnt    <= 4'd0;
      errcnt <= 4'd0;
    end else begin
      state  <= state_nx;
      p      <= p_nx;
      cnt    <= cnt_nx;
      errcnt <= errcnt_nx;
    end
  end

  // Rotate: lane p of the previous word becomes byte 0. Upper bytes come from the current word.
  always_comb begin
    case (p)
      2'd0:    aligned_data = d1_data;
      2'd1:    aligned_data = {bus.rxdata_fis[7:0],  d1_data[31:8]};
      2'd2:    aligned_data = {bus.rxdata_fis[15:0], d1_data[31:16]};
      default: aligned_data = {bus.rxdata_fis[23:0], d1_data[31:24]};
    endcase
  end

  assign aligned_k = d1_k[p];
  assign is_align  = aligned_k && (aligned_data == ALIGN_PRIM);
  assign qual      = d1_tag && link_up;

  // Input delay stage and registered link-layer outputs.
  always_ff @(posedge clk_75m or posedge host_rst) begin
    if (host_rst) begin
      d1_data          <= 32'd0;
      d1_k             <= 4'd0;
      d1_tag           <= 1'b0;
      bus.phy2cs_data  <= 32'd0;
      bus.phy2cs_k     <= 1'b0;
      bus.phy2cs_valid <= 1'b0;
      align_det        <= 1'b0;
      rx_err           <= 1'b0;
    end else begin
      d1_data          <= bus.rxdata_fis;
      d1_k             <= bus.rxcharisk;
      d1_tag           <= link_up && (state == SYNC);
      bus.phy2cs_data  <= aligned_data;
      bus.phy2cs_k     <= aligned_k;
      bus.phy2cs_valid <= qual && !(DROP_ALIGN && is_align);
      align_det        <= qual && is_align;
      rx_err           <= err_nx;
    end
  end

  assign rx_locked   = (state == SYNC);
  assign align_shift = rx_locked ? p : 2'd0;
  assign dbg_state   = state;

endmodule

// File: tb/tb_sata_rx_dword_align.sv
// tb_sata_rx_dword_align: directed vectors for the receive dword aligner.
// The vectors cover lane-0 and lane-2 lock, sync loss, link drop, ACQ lane
// change and async reset.
module tb_sata_rx_dword_align;

  localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
`ifdef SATA_RX_ALIGN_DROP_EN
  localparam logic EXP_ALIGN_VALID = 1'b0;
`else
  localparam logic EXP_ALIGN_VALID = 1'b1;
`endif

  logic        clk_75m;
  logic        host_rst;
  logic        link_up;
  logic        rx_locked;
  logic [1:0]  align_shift;
  logic        align_det;
  logic        rx_err;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_err;

  sata_rx_dword_align_if bus_if ();

  sata_rx_dword_align dut (
    .clk_75m     (clk_75m),
    .host_rst    (host_rst),
    .link_up     (link_up),
    .bus         (bus_if),
    .rx_locked   (rx_locked),
    .align_shift (align_shift),
    .align_det   (align_det),
    .rx_err      (rx_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk_75m = 1'b0;
    forever #5 clk_75m = ~clk_75m;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one raw word. On return, the outputs show the edge that sampled it.
  task automatic send(input logic [31:0] data, input logic [3:0] k);
    bus_if.rxdata_fis = data;
    bus_if.rxcharisk  = k;
    @(posedge clk_75m);
    #1;
  endtask

  task automatic do_reset();
    host_rst = 1'b1;
    bus_if.rxdata_fis = 32'd0;
    bus_if.rxcharisk  = 4'd0;
    repeat (2) @(posedge clk_75m);
    #1;
    host_rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    link_up  = 1'b1;

    // 1. reset with idle input
    do_reset();
    check("rst_locked", rx_locked, 0);
    check("rst_valid",  bus_if.phy2cs_valid, 0);
    check("rst_data",   bus_if.phy2cs_data, 0);
    check("rst_shift",  align_shift, 0);
    check("rst_state",  dbg_state, 0);
    send(32'd0, 4'd0);
    send(32'd0, 4'd0);
    check("idle_locked", rx_locked, 0);
    check("idle_err",    rx_err, 0);
    check("idle_det",    align_det, 0);

    // 2. lane-0 lock
    send(ALIGN, 4'b0001);
    send(ALIGN, 4'b0001);
    check("l0_not_yet", rx_locked, 0);
    send(ALIGN, 4'b0001);
    check("l0_locked", rx_locked, 1);
    check("l0_shift",  align_shift, 0);
    send(ALIGN, 4'b0001);               // out: locking comma, not valid
    check("l0_lockword_valid", bus_if.phy2cs_valid, 0);
    send(32'h1122_3344, 4'b0000);       // out: ALIGN sent in SYNC
    check("l0_align_data",  bus_if.phy2cs_data, ALIGN);
    check("l0_align_k",     bus_if.phy2cs_k, 1);
    check("l0_align_valid", bus_if.phy2cs_valid, EXP_ALIGN_VALID);
    check("l0_align_det",   align_det, 1);
    send(32'd0, 4'b0000);               // out: data word
    check("l0_data",       bus_if.phy2cs_data, 32'h1122_3344);
    check("l0_data_k",     bus_if.phy2cs_k, 0);
    check("l0_data_valid", bus_if.phy2cs_valid, 1);
    check("l0_data_det",   align_det, 0);

    // 4. loss of sync: three bad + good keeps lock, then four bad drops it
    for (int i = 0; i < 3; i++) begin
      send(32'h0000_BC00, 4'b0010);
      check("bad3_err",    rx_err, 1);
      check("bad3_locked", rx_locked, 1);
    end
    send(32'd0, 4'b0000);
    check("good_err",    rx_err, 0);
    check("good_locked", rx_locked, 1);
    for (int i = 0; i < 3; i++) begin
      send(32'h0000_BC00, 4'b0010);
      check("bad_err", rx_err, 1);
      check("bad_locked", rx_locked, 1);
    end
    send(32'h0000_BC00, 4'b0010);
    check("bad4_err",    rx_err, 1);
    check("bad4_locked", rx_locked, 0);
    send(32'd0, 4'b0000);
    check("after_loss_err", rx_err, 0);

    // 5. link_up drop during SYNC
    send(ALIGN, 4'b0001);
    send(ALIGN, 4'b0001);
    send(ALIGN, 4'b0001);
    check("relock", rx_locked, 1);
    send(32'h0102_0304, 4'b0000);
    send(32'h0506_0708, 4'b0000);
    check("pre_drop_data",  bus_if.phy2cs_data, 32'h0102_0304);
    check("pre_drop_valid", bus_if.phy2cs_valid, 1);
    link_up = 1'b0;
    send(32'h090A_0B0C, 4'b0000);
    check("drop_locked", rx_locked, 0);
    check("drop_valid",  bus_if.phy2cs_valid, 0);
    link_up = 1'b1;
    send(ALIGN, 4'b0001);
    check("drop_valid2", bus_if.phy2cs_valid, 0);
    send(ALIGN, 4'b0001);
    check("relock_2", rx_locked, 0);
    send(ALIGN, 4'b0001);
    check("relock_3", rx_locked, 1);

    // 3. lane-2 rotation, fresh start
    do_reset();
    send(32'h4ABC_5566, 4'b0100);
    send(32'h4ABC_7B4A, 4'b0100);
    send(32'h4ABC_7B4A, 4'b0100);
    check("l2_locked", rx_locked, 1);
    check("l2_shift",  align_shift, 2);
    send(32'h4ABC_7B4A, 4'b0100);       // out: locking comma dword
    check("l2_lock_data",  bus_if.phy2cs_data, ALIGN);
    check("l2_lock_k",     bus_if.phy2cs_k, 1);
    check("l2_lock_valid", bus_if.phy2cs_valid, 0);
    send(32'h3344_7B4A, 4'b0000);       // out: ALIGN in SYNC
    check("l2_align_data",  bus_if.phy2cs_data, ALIGN);
    check("l2_align_valid", bus_if.phy2cs_valid, EXP_ALIGN_VALID);
    check("l2_align_det",   align_det, 1);
    send(32'hCCDD_1122, 4'b0000);
    check("l2_data0",  bus_if.phy2cs_data, 32'h1122_3344);
    check("l2_data0_k", bus_if.phy2cs_k, 0);
    check("l2_data0_v", bus_if.phy2cs_valid, 1);
    send(32'h0000_AABB, 4'b0000);
    check("l2_data1",  bus_if.phy2cs_data, 32'hAABB_CCDD);
    check("l2_data1_v", bus_if.phy2cs_valid, 1);
    check("l2_err",    rx_err, 0);

    // async reset mid-stream
    bus_if.rxdata_fis = 32'h1234_5678;
    bus_if.rxcharisk  = 4'b0000;
    #2;
    host_rst = 1'b1;
    #1;
    check("arst_locked", rx_locked, 0);
    check("arst_valid",  bus_if.phy2cs_valid, 0);
    check("arst_data",   bus_if.phy2cs_data, 0);
    check("arst_shift",  align_shift, 0);
    #2;
    host_rst = 1'b0;
    send(32'h1234_5678, 4'b0000);
    check("post_arst_data",  bus_if.phy2cs_data, 0);
    check("post_arst_valid", bus_if.phy2cs_valid, 0);
    send(32'h9ABC_DEF0, 4'b0000);
    check("post_arst_valid2", bus_if.phy2cs_valid, 0);
    check("post_arst_state",  dbg_state, 0);

    // 6. ACQ lane change
    send(32'h0000_BC00, 4'b0010);
    check("acq_state", dbg_state, 1);
    send(32'hBC00_0000, 4'b1000);
    send(32'hBC00_0000, 4'b1000);
    check("acq_l3_2", rx_locked, 0);
    send(32'hBC00_0000, 4'b1000);
    check("acq_l3_3",    rx_locked, 1);
    check("acq_shift",   align_shift, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
